// File: rtl/result_bus_arbiter.sv
// result_bus_arbiter: round-robin arbiter that shares one registered result bus among 4 requesters.
// Results addressed to register 0 are acknowledged but dropped.
module result_bus_arbiter #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] req_data0,
    input  logic [WIDTH-1:0] req_data1,
    input  logic [WIDTH-1:0] req_data2,
    input  logic [WIDTH-1:0] req_data3,
    input  logic [IDXW-1:0]  req_dest0,
    input  logic [IDXW-1:0]  req_dest1,
    input  logic [IDXW-1:0]  req_dest2,
    input  logic [IDXW-1:0]  req_dest3,
    output logic [3:0]       ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDXW-1:0]  out_dest,
    output logic [1:0]       out_src
);
    logic [1:0]       ptr;
    logic [1:0]       win;
    logic             free;
    logic             load;
    logic [WIDTH-1:0] data_a [4];
    logic [IDXW-1:0]  dest_a [4];

    always_comb begin
        data_a[0] = req_data0;
        data_a[1] = req_data1;
        data_a[2] = req_data2;
        data_a[3] = req_data3;
        dest_a[0] = req_dest0;
        dest_a[1] = req_dest1;
        dest_a[2] = req_dest2;
        dest_a[3] = req_dest3;
    end

    // Scan from the farthest position back so the nearest requester at or after ptr wins.
    always_comb begin
        win = ptr;
        for (int k = 3; k >= 0; k--)
            if (req[ptr + 2'(k)]) win = ptr + 2'(k);
    end

    assign free = !out_valid || out_ready;
    assign load = rst_n && free && |req;
    assign ack  = load ? (4'b0001 << win) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_dest  <= '0;
            out_src   <= '0;
        end else if (load) begin
            ptr <= win + 2'd1;
            if (dest_a[win] != '0) begin
                out_valid <= 1'b1;
                out_data  <= data_a[win];
                out_dest  <= dest_a[win];
                out_src   <= win;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (free) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_result_bus_arbiter.sv
// tb_result_bus_arbiter: directed scenarios plus randomized traffic against a
// behavioural round-robin model of the result bus arbiter.
module tb_result_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] rd [4];
    logic [4:0]  rdst [4];
    logic [3:0]  ack;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_dest;
    logic [1:0]  out_src;

    int tests = 0;
    int fails = 0;

    int          m_ptr;
    bit          m_valid;
    logic [31:0] m_data;
    logic [4:0]  m_dest;
    logic [1:0]  m_src;

    result_bus_arbiter #(.WIDTH(32), .IDXW(5)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .req_data0(rd[0]), .req_data1(rd[1]), .req_data2(rd[2]), .req_data3(rd[3]),
        .req_dest0(rdst[0]), .req_dest1(rdst[1]), .req_dest2(rdst[2]), .req_dest3(rdst[3]),
        .ack(ack), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_dest(out_dest), .out_src(out_src)
    );

    always #5 clk = ~clk;

    function automatic int mwin(logic [3:0] r, int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'b0000;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd[i] = 32'h1000_0000 + i;
            rdst[i] = 5'(i + 1);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b1111;
        out_ready = 1'b1;
        #3;
        tests++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_dest !== 5'd0 || out_src !== 2'd0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b d=%h dst=%0d src=%0d, want all zero", out_valid, out_data, out_dest, out_src);
        end
        tests++;
        if (ack !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ack: got %b want 0000", ack);
        end
        tick();
        tests++;
        if (ack !== 4'b0000 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_edge: got ack=%b v=%b want 0000/0", ack, out_valid);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        req = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if (ack !== 4'(1 << (i % 4))) begin
                fails++;
                $display("FAIL rotation_ack[%0d]: got %b want %b", i, ack, 4'(1 << (i % 4)));
            end
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_src !== 2'(i % 4) || out_data !== 32'h1000_0000 + 32'(i % 4)) begin
                fails++;
                $display("FAIL rotation_out[%0d]: got v=%b src=%0d d=%h want 1/%0d", i, out_valid, out_src, out_data, i % 4);
            end
        end
    endtask

    task automatic test_hold_and_chain();
        do_reset();
        req = 4'b0100;
        rd[2] = 32'hDEADBEEF;
        rdst[2] = 5'd7;
        out_ready = 1'b0;
        #1;
        tests++;
        if (ack !== 4'b0100) begin
            fails++;
            $display("FAIL hold_first_ack: got %b want 0100", ack);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_dest !== 5'd7 || ack !== 4'b0000) begin
                fails++;
                $display("FAIL hold_cycle[%0d]: got v=%b d=%h dst=%0d ack=%b want 1/DEADBEEF/7/0000", i, out_valid, out_data, out_dest, ack);
            end
        end
        req = 4'b0001;
        rd[0] = 32'hCAFE0001;
        rdst[0] = 5'd3;
        out_ready = 1'b1;
        #1;
        tests++;
        if (ack !== 4'b0001) begin
            fails++;
            $display("FAIL chain_ack: got %b want 0001", ack);
        end
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hCAFE0001 || out_dest !== 5'd3 || out_src !== 2'd0) begin
            fails++;
            $display("FAIL chain_out: got v=%b d=%h dst=%0d src=%0d want 1/CAFE0001/3/0", out_valid, out_data, out_dest, out_src);
        end
    endtask

    task automatic test_dest_zero();
        do_reset();
        req = 4'b0010;
        rdst[1] = 5'd0;
        out_ready = 1'b0;
        #1;
        tests++;
        if (ack !== 4'b0010) begin
            fails++;
            $display("FAIL dest0_ack: got %b want 0010", ack);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_dest !== 5'd0 || out_src !== 2'd0) begin
            fails++;
            $display("FAIL dest0_out: got v=%b d=%h dst=%0d src=%0d want all zero", out_valid, out_data, out_dest, out_src);
        end
        req = 4'b1111;
        rdst[1] = 5'd9;
        #1;
        tests++;
        if (ack !== 4'b0100) begin
            fails++;
            $display("FAIL dest0_ptr: got ack %b want 0100", ack);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req = 4'b0100;
        out_ready = 1'b1;
        tick();
        req = 4'b1001;
        #1;
        tests++;
        if (ack !== 4'b1000) begin
            fails++;
            $display("FAIL wrap_ack: got %b want 1000", ack);
        end
        tick();
        tests++;
        if (out_src !== 2'd3 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL wrap_src: got src=%0d v=%b want 3/1", out_src, out_valid);
        end
        req = 4'b1111;
        #1;
        tests++;
        if (ack !== 4'b0001) begin
            fails++;
            $display("FAIL wrap_ptr: got ack %b want 0001", ack);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0001;
        out_ready = 1'b1;
        tick();
        req = 4'b0010;
        #1;
        tests++;
        if (ack !== 4'b0010 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL areset_pre: got ack=%b v=%b want 0010/1", ack, out_valid);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || ack !== 4'b0000 || out_data !== 32'd0 || out_src !== 2'd0) begin
            fails++;
            $display("FAIL areset_now: got v=%b ack=%b d=%h src=%0d want 0/0000/0/0", out_valid, ack, out_data, out_src);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int w;
        do_reset();
        m_ptr = 0;
        m_valid = 1'b0;
        m_data = '0;
        m_dest = '0;
        m_src = '0;
        for (int n = 0; n < 400; n++) begin
            req = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                rd[i] = $urandom;
                rdst[i] = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            end
            #1;
            w = (!m_valid || out_ready) ? mwin(req, m_ptr) : -1;
            tests++;
            if (ack !== ((w >= 0) ? 4'(1 << w) : 4'b0000)) begin
                fails++;
                $display("FAIL rand_ack[%0d]: got %b want %b", n, ack, (w >= 0) ? 4'(1 << w) : 4'b0000);
            end
            if (w >= 0) begin
                m_ptr = (w + 1) % 4;
                if (rdst[w] != 0) begin
                    m_valid = 1'b1;
                    m_data = rd[w];
                    m_dest = rdst[w];
                    m_src = 2'(w);
                end else begin
                    m_valid = 1'b0;
                end
            end else if (!m_valid || out_ready) begin
                m_valid = 1'b0;
            end
            tick();
            tests++;
            if (out_valid !== m_valid || out_data !== m_data || out_dest !== m_dest || out_src !== m_src) begin
                fails++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h dst=%0d src=%0d want %b/%h/%0d/%0d",
                         n, out_valid, out_data, out_dest, out_src, m_valid, m_data, m_dest, m_src);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req = 4'b0000;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd[i] = '0;
            rdst[i] = '0;
        end
        test_reset();
        test_rotation();
        test_hold_and_chain();
        test_dest_zero();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/result_bus_arbiter.md
RESULT_BUS_ARBITER -- requirements
Module: result_bus_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the result data width.
REQ-002 The block SHALL have parameter IDXW, default 5, which sets the destination register index width.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock, rising-edge active.
REQ-004 Port rst_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-005 Port req SHALL be an input, 4 bits wide: per-requester request; req[i] high means the requester holds a result.
REQ-006 Ports req_data0..req_data3 SHALL be inputs, WIDTH bits wide each: the result from requester i.
REQ-007 Ports req_dest0..req_dest3 SHALL be inputs, IDXW bits wide each: the destination register index from requester i.
REQ-008 Port ack SHALL be an output, 4 bits wide: one-hot acceptance; ack[i] high means requester i's result is taken on this clock edge.
REQ-009 Port out_valid SHALL be an output, 1 bit wide: the output register holds a result.
REQ-010 Port out_ready SHALL be an input, 1 bit wide: the consumer (register-file write port) accepts the result on this edge.
REQ-011 Port out_data SHALL be an output, WIDTH bits wide: the held result.
REQ-012 Port out_dest SHALL be an output, IDXW bits wide: the held destination index.
REQ-013 Port out_src SHALL be an output, 2 bits wide: the index of the requester that supplied the held result.

Function
REQ-014 The block SHALL share one registered WIDTH-bit result bus among 4 requesters using round-robin priority.
REQ-015 The output register SHALL be free in a cycle when out_valid=0 or out_ready=1.
REQ-016 The block SHALL load in a cycle when the output register is free and |req=1.
REQ-017 The winner SHALL be the first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-018 ack SHALL be combinational: ack[winner]=1 on a load cycle, all zero otherwise, and at most one bit high.
REQ-019 On a load edge, ptr SHALL become (winner+1) mod 4, and out_data, out_dest and out_src SHALL capture the winner's values.
REQ-020 On a load edge, out_valid SHALL be set to 1.
REQ-021 When the output register is free, out_ready=1 and there is no load, out_valid SHALL be cleared to 0 on the edge.
REQ-022 If out_valid=1 and out_ready=0, out_data, out_dest, out_src and ptr SHALL hold, and ack SHALL be 0.
REQ-023 Latency SHALL be 1 cycle: out_valid rises on the edge at which ack is high.
REQ-024 Throughput SHALL be 1 result per cycle when out_ready is held at 1.
REQ-025 A load where the winner's dest equals 0 (hardwired zero register) SHALL still assert ack and advance ptr.
REQ-026 On such a dest-0 load, out_valid SHALL take the value it would have with no load, and out_data, out_dest and out_src SHALL not change.
REQ-027 Requesters SHALL hold req and data stable until acked; the block SHALL tolerate req deasserting without an ack, with no state change.
REQ-028 When req goes high in the same cycle as a consume (out_valid=1, out_ready=1), the new result SHALL be loaded on that edge, with no bubble.
REQ-029 ptr SHALL wrap from 3 to 0.

Reset
REQ-030 When rst_n=0, out_valid, out_data, out_dest and out_src SHALL be 0 and ptr SHALL be 0, immediately and independent of clk.
REQ-031 ack SHALL be forced to 0 while rst_n=0.
REQ-032 If reset is asserted while a result is held, that result SHALL be discarded and no ack SHALL be issued.
REQ-033 On the first rising edge after rst_n rises, the block SHALL arbitrate normally with ptr=0.

Verification
REQ-034 Reset, then req=4'b1111 with all dests nonzero and out_ready=1: acks SHALL go 0001, 0010, 0100, 1000, 0001 on consecutive cycles, and out_src SHALL go 0,1,2,3,0 one cycle later.
REQ-035 req=4'b0100, req_data2=32'hDEADBEEF, req_dest2=5'd7, out_ready=0: ack SHALL be 0100 for one cycle, then out_valid=1, out_data=DEADBEEF, out_dest=7 held with ack=0.
REQ-036 Continuing REQ-035, raise out_ready with req=4'b0001: the edge SHALL consume and load requester 0 together, with out_valid staying 1.
REQ-037 req=4'b0010 with req_dest1=0 and out_valid=0: ack SHALL be 0010, out_valid SHALL stay 0, and ptr SHALL become 2.
REQ-038 With a result held and ack high, assert rst_n=0 mid-cycle: out_valid and ack SHALL go to 0 at once, with no clock edge needed.
REQ-039 ptr=3 with req=4'b1001: the winner SHALL be 3 and ptr SHALL then become 0.
